btn_flag_gen: RTL and testbench

Per-button front end feeding the game board's rd/rst flag inputs and the random-mode toggle logic. Takes one raw, asynchronous, bouncing push-button level and produces:
- a debounced level
- a one-cycle press flag
- a long-press flag
- a press-toggled state bit
One instance per button, all on the divided game clock.

---
 rtl/btn_flag_gen.sv | 132 +++++++++++++
 tb/tb_btn_flag_gen.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/btn_flag_gen.sv
// Per-button front end: 2-FF synchronizer, debounce FSM, press/long-press flags and a toggle bit.
// Define AUTO_REPEAT_EN to make flag re-pulse every REPEAT_CYC cycles after a long press.
module btn_flag_gen #(
    parameter int unsigned DEBOUNCE_CYC = 4,
    parameter int unsigned LONG_CYC     = 16,
    parameter int unsigned REPEAT_CYC   = 8,
    parameter int unsigned CNT_W        = 8
) (
    input  logic clk,
    input  logic rst_sw,
    input  logic btn_in,
    output logic held,
    output logic flag,
    output logic long_flag,
    output logic toggle
);

    typedef enum logic [1:0] {
        StIdle,
        StPressDb,
        StHeld,
        StRelDb
    } state_e;

    localparam logic [CNT_W-1:0] DbLast   = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] LongMax  = CNT_W'(LONG_CYC);
    localparam logic [CNT_W-1:0] LongLast = CNT_W'(LONG_CYC - 1);

    state_e           state_q;
    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] db_cnt_q;
    logic [CNT_W-1:0] hold_cnt_q;

`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RepLast = CNT_W'(REPEAT_CYC - 1);
    logic [CNT_W-1:0] rep_cnt_q;
`else
    logic unused_repeat_cyc;
    assign unused_repeat_cyc = ^REPEAT_CYC;
`endif

    always_ff @(posedge clk or negedge rst_sw) begin
        if (!rst_sw) begin
            state_q    <= StIdle;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
            held       <= 1'b0;
            flag       <= 1'b0;
            long_flag  <= 1'b0;
            toggle     <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rep_cnt_q  <= '0;
`endif
        end else begin
            sync1_q   <= btn_in;
            sync2_q   <= sync1_q;
            flag      <= 1'b0;
            long_flag <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (sync2_q) begin
                        state_q  <= StPressDb;
                        db_cnt_q <= '0;
                    end
                end

                StPressDb: begin
                    if (!sync2_q) begin
                        state_q <= StIdle;
                    end else if (db_cnt_q == DbLast) begin
                        state_q    <= StHeld;
                        held       <= 1'b1;
                        flag       <= 1'b1;
                        toggle     <= ~toggle;
                        hold_cnt_q <= '0;
`ifdef AUTO_REPEAT_EN
                        rep_cnt_q  <= '0;
`endif
                    end else begin
                        db_cnt_q <= db_cnt_q + 1'b1;
                    end
                end

                StHeld: begin
                    if (!sync2_q) begin
                        state_q  <= StRelDb;
                        db_cnt_q <= '0;
                    end else if (hold_cnt_q < LongMax) begin
                        // Saturating, so long_flag can fire only once per press.
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                        if (hold_cnt_q == LongLast) begin
                            long_flag <= 1'b1;
                        end
`ifdef AUTO_REPEAT_EN
                    end else if (rep_cnt_q == RepLast) begin
                        flag      <= 1'b1;
                        toggle    <= ~toggle;
                        rep_cnt_q <= '0;
                    end else begin
                        rep_cnt_q <= rep_cnt_q + 1'b1;
`endif
                    end
                end

                StRelDb: begin
                    // A bounce back to high resumes HELD with counters intact and no new flag.
                    if (sync2_q) begin
                        state_q <= StHeld;
                    end else if (db_cnt_q == DbLast) begin
                        state_q <= StIdle;
                        held    <= 1'b0;
`ifdef AUTO_REPEAT_EN
                        rep_cnt_q <= '0;
`endif
                    end else begin
                        db_cnt_q <= db_cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= StIdle;
                    held    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_flag_gen.sv
// Scoreboard bench for btn_flag_gen: expected pulses and held levels are queued when
// stimulus is driven and compared by a negedge monitor.
module tb_btn_flag_gen;

    localparam int DEB = 4;
    localparam int LNG = 16;
    localparam int REP = 8;

    logic clk = 1'b0;
    logic rst_sw = 1'b1;
    logic btn_in = 1'b0;
    logic held, flag, long_flag, toggle;

    btn_flag_gen #(
        .DEBOUNCE_CYC(DEB),
        .LONG_CYC    (LNG),
        .REPEAT_CYC  (REP),
        .CNT_W       (8)
    ) u_dut (
        .clk      (clk),
        .rst_sw   (rst_sw),
        .btn_in   (btn_in),
        .held     (held),
        .flag     (flag),
        .long_flag(long_flag),
        .toggle   (toggle)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int cyc; logic is_long; logic tog;} ev_t;
    typedef struct {int cyc; logic val;} hc_t;

    ev_t  ev_q[$];
    hc_t  hq[$];
    ev_t  mon_e;
    hc_t  mon_h;
    int   n_checks = 0;
    int   n_fail = 0;
    logic exp_tog = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_flag(input int c);
        exp_tog = ~exp_tog;
        ev_q.push_back('{c, 1'b0, exp_tog});
    endtask

    task automatic push_long(input int c);
        ev_q.push_back('{c, 1'b1, exp_tog});
    endtask

    task automatic push_held(input int c, input logic v);
        hq.push_back('{c, v});
    endtask

    // e1: first edge sampling btn high; the FSM acts on high samples through edge e1+n_high+1.
    task automatic push_press(input int e1, input int n_high);
        int r1, fl, lg;
        r1 = e1 + n_high;
        fl = e1 + DEB + 2;
        lg = fl + LNG;
        if (n_high >= DEB + 1) begin
            push_held(fl - 1, 1'b0);
            push_held(fl, 1'b1);
            push_flag(fl);
            if (lg <= r1 + 1) begin
                push_long(lg);
`ifdef AUTO_REPEAT_EN
                for (int x = lg + REP; x <= r1 + 1; x += REP) push_flag(x);
`endif
            end
            push_held(r1 + DEB + 1, 1'b1);
            push_held(r1 + DEB + 2, 1'b0);
        end else begin
            push_held(e1 + DEB + 3, 1'b0);
        end
    endtask

    task automatic press(input int n_high, input int n_low);
        btn_in = 1'b1;
        push_press(cyc + 1, n_high);
        repeat (n_high) @(negedge clk);
        btn_in = 1'b0;
        repeat (n_low) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (flag || long_flag) begin
            if (ev_q.size() == 0) begin
                check_eq("spurious_pulse", {30'd0, flag, long_flag}, 32'd0);
            end else begin
                mon_e = ev_q.pop_front();
                check_eq("pulse_cycle", cyc, mon_e.cyc);
                check_eq("pulse_kind", {30'd0, flag, long_flag},
                         mon_e.is_long ? 32'd1 : 32'd2);
                check_eq("pulse_toggle", {31'd0, toggle}, {31'd0, mon_e.tog});
            end
        end
        if (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
            mon_e = ev_q.pop_front();
            check_eq("missed_pulse", cyc, mon_e.cyc);
        end
        if (hq.size() > 0 && hq[0].cyc == cyc) begin
            mon_h = hq.pop_front();
            check_eq("held_level", {31'd0, held}, {31'd0, mon_h.val});
        end
    end

    initial begin
        int e1, fl, r1, r2;

        // Reset and idle
        rst_sw = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_held", {31'd0, held}, 32'd0);
        check_eq("rst_flag", {31'd0, flag}, 32'd0);
        check_eq("rst_long", {31'd0, long_flag}, 32'd0);
        check_eq("rst_toggle", {31'd0, toggle}, 32'd0);
        rst_sw = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("idle_held", {31'd0, held}, 32'd0);
        check_eq("idle_toggle", {31'd0, toggle}, 32'd0);

        // Clean press
        press(30, 12);
        check_eq("press_toggle", {31'd0, toggle}, {31'd0, exp_tog});

        // Bounce on press: never stable long enough
        btn_in = 1'b1;
        e1 = cyc + 1;
        push_held(e1 + 8, 1'b0);
        push_held(e1 + 12, 1'b0);
        repeat (2) @(negedge clk);
        btn_in = 1'b0;
        repeat (1) @(negedge clk);
        btn_in = 1'b1;
        repeat (2) @(negedge clk);
        btn_in = 1'b0;
        repeat (12) @(negedge clk);
        check_eq("bounce_toggle", {31'd0, toggle}, {31'd0, exp_tog});

        // Release bounce while held, then a second full press
        btn_in = 1'b1;
        e1 = cyc + 1;
        fl = e1 + DEB + 2;
        push_held(fl - 1, 1'b0);
        push_held(fl, 1'b1);
        push_flag(fl);
        repeat (12) @(negedge clk);
        btn_in = 1'b0;
        r1 = e1 + 12;
        r2 = e1 + 20;
        push_held(r1 + 3, 1'b1);
        push_held(r1 + 5, 1'b1);
        push_held(r2 + DEB + 1, 1'b1);
        push_held(r2 + DEB + 2, 1'b0);
        repeat (2) @(negedge clk);
        btn_in = 1'b1;
        repeat (6) @(negedge clk);
        btn_in = 1'b0;
        repeat (12) @(negedge clk);
        check_eq("relbounce_toggle", {31'd0, toggle}, {31'd0, exp_tog});
        press(20, 12);
        check_eq("second_toggle", {31'd0, toggle}, {31'd0, exp_tog});

        // Reset while held; held button re-debounces after reset
        btn_in = 1'b1;
        e1 = cyc + 1;
        fl = e1 + DEB + 2;
        push_held(fl - 1, 1'b0);
        push_held(fl, 1'b1);
        push_flag(fl);
        repeat (DEB + 4) @(negedge clk);
        rst_sw = 1'b0;
        #1;
        check_eq("midrst_held", {31'd0, held}, 32'd0);
        check_eq("midrst_flag", {31'd0, flag}, 32'd0);
        check_eq("midrst_long", {31'd0, long_flag}, 32'd0);
        check_eq("midrst_toggle", {31'd0, toggle}, 32'd0);
        exp_tog = 1'b0;
        repeat (2) @(negedge clk);
        rst_sw = 1'b1;
        push_press(cyc + 1, 24);
        repeat (24) @(negedge clk);
        btn_in = 1'b0;
        repeat (12) @(negedge clk);

        // Long hold: one flag, one long_flag, plus repeats when enabled
        press(60, 12);
        check_eq("long_toggle", {31'd0, toggle}, {31'd0, exp_tog});

        check_eq("pending_pulses", ev_q.size(), 32'd0);
        check_eq("pending_held", hq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
